// File: rtl/alu_mul_sequencer_if.sv
// Request/response and shared-ALU signal bundle for alu_mul_sequencer.
// The sequencer connects through the slave modport; the requester/ALU side uses master.
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             ovf;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             alu_cout;

  modport slave (
    input  start, flush, a_in, b_in, alu_c, alu_cout,
    output busy, done, product, ovf, alu_a, alu_b, alu_cin, alu_op
  );

  modport master (
    output start, flush, a_in, b_in, alu_c, alu_cout,
    input  busy, done, product, ovf, alu_a, alu_b, alu_cin, alu_op
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 multiplier (low half) issuing one shared-ALU op per cycle.
// Optional MUL_EARLY_EXIT_EN: stop iterating once the remaining multiplier is zero.
`ifndef OP_ID
`define OP_ID  4'h0
`endif
`ifndef OP_ADD
`define OP_ADD 4'h1
`endif
`ifndef OP_ALS
`define OP_ALS 4'h8
`endif

module alu_mul_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_mul_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_ADD,
    S_SHL,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_ovf_q, run_ovf_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   alu_a_c;
  logic [WIDTH-1:0]   alu_b_c;
  logic [3:0]         alu_op_c;
  logic               done_c;
  logic               iter_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      run_ovf_q <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      run_ovf_q <= run_ovf_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef MUL_EARLY_EXIT_EN
  assign iter_end = (cnt_q == CNT_W'(WIDTH)) || (q_q == '0);
`else
  assign iter_end = (cnt_q == CNT_W'(WIDTH));
`endif

  // Overflow accumulates in run_ovf_q so the visible ovf stays paired with product
  // and survives a flush untouched.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    run_ovf_d = run_ovf_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    alu_a_c   = '0;
    alu_b_c   = '0;
    alu_op_c  = `OP_ID;
    done_c    = 1'b0;

    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            acc_d     = '0;
            m_d       = bus.a_in;
            q_d       = bus.b_in;
            cnt_d     = '0;
            run_ovf_d = 1'b0;
            state_d   = S_CHK;
          end
        end
        S_CHK: begin
          if (iter_end)      state_d = S_DONE;
          else if (q_q[0])   state_d = S_ADD;
          else               state_d = S_SHL;
        end
        S_ADD: begin
          alu_op_c  = `OP_ADD;
          alu_a_c   = acc_q;
          alu_b_c   = m_q;
          acc_d     = bus.alu_c;
          run_ovf_d = run_ovf_q | bus.alu_cout;
          state_d   = S_SHL;
        end
        S_SHL: begin
          alu_op_c  = `OP_ALS;
          alu_a_c   = m_q;
          m_d       = bus.alu_c;
          q_d       = q_q >> 1;
          cnt_d     = cnt_q + CNT_W'(1);
          // A set multiplicand bit lost while multiplier bits remain would land above bit 15.
          run_ovf_d = run_ovf_q | (m_q[WIDTH-1] & ((q_q >> 1) != '0));
          state_d   = S_CHK;
        end
        S_DONE: begin
          product_d = acc_q;
          ovf_d     = run_ovf_q;
          done_c    = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_c;
  assign bus.product = product_q;
  assign bus.ovf     = ovf_q;
  assign bus.alu_a   = alu_a_c;
  assign bus.alu_b   = alu_b_c;
  assign bus.alu_op  = alu_op_c;
  assign bus.alu_cin = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed plus randomized bench for alu_mul_sequencer with a behavioural ALU and
// an arithmetic reference model of product, overflow and latency.
`ifndef OP_ID
`define OP_ID  4'h0
`endif
`ifndef OP_ADD
`define OP_ADD 4'h1
`endif
`ifndef OP_ALS
`define OP_ALS 4'h8
`endif

module tb_alu_mul_sequencer;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   add_cnt;
  int   cin_bad;

  logic [15:0] exp_prod;
  logic        exp_ovf;

  alu_mul_sequencer_if #(.WIDTH(16)) bus ();

  alu_mul_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared combinational ALU
  always_comb begin
    bus.alu_c    = bus.alu_a;
    bus.alu_cout = 1'b0;
    case (bus.alu_op)
      `OP_ADD: {bus.alu_cout, bus.alu_c} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, bus.alu_cin};
      `OP_ALS: {bus.alu_cout, bus.alu_c} = {bus.alu_a, 1'b0};
      default: begin
        bus.alu_c    = bus.alu_a;
        bus.alu_cout = 1'b0;
      end
    endcase
  end

  initial begin
    add_cnt = 0;
    cin_bad = 0;
  end
  always @(negedge clk) begin
    if (bus.alu_op == `OP_ADD) add_cnt = add_cnt + 1;
    if (bus.alu_cin !== 1'b0)  cin_bad = cin_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] b);
    int pc;
    int n;
    pc = $countones(b);
    n  = 0;
`ifdef MUL_EARLY_EXIT_EN
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    return 2 * n + pc + 2;
`else
    return 2 * 16 + pc + 2 + n;
`endif
  endfunction

  // One complete multiply; optionally pokes start mid-run or in the done cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input bit mid_start, input bit done_start);
    int n;
    int adds0;
    bit busy_ok;
    int extra_done;
    longint unsigned full;
    full  = longint'(a) * longint'(b);
    adds0 = add_cnt;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!bus.done && n < 200) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (mid_start && n == 10) begin
        bus.a_in  = ~a;
        bus.b_in  = b ^ 16'h5A5A;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    chk("latency", n, exp_latency(b));
    chk("busy_during_op", {31'd0, busy_ok & bus.busy}, 32'd1);
    if (done_start) begin
      bus.a_in  = 16'h0003;
      bus.b_in  = 16'h0003;
      bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    exp_prod = full[15:0];
    exp_ovf  = (full >> 16) != 0;
    chk("product", bus.product, exp_prod);
    chk("ovf", bus.ovf, exp_ovf);
    chk("busy_after_done", bus.busy, 1'b0);
    if (b == 16'd0) chk("no_add_for_b0", add_cnt - adds0, 0);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) extra_done++;
      @(posedge clk); #1;
    end
    if (mid_start || done_start) begin
      chk("extra_done", extra_done, 0);
      chk("still_idle", bus.busy, 1'b0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    exp_prod  = '0;
    exp_ovf   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_product", bus.product, 16'd0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_alu_op", bus.alu_op, `OP_ID);
    chk("rst_alu_a", bus.alu_a, 16'd0);
    chk("rst_alu_b", bus.alu_b, 16'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0003, 16'h0005, 1'b0, 1'b0);
    chk("t1_product", bus.product, 16'h000F);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    chk("t2_ovf", bus.ovf, 1'b1);
    run_op(16'h1234, 16'h0000, 1'b0, 1'b0);
    run_op(16'h0000, 16'hBEEF, 1'b0, 1'b0);
    run_op(16'h0100, 16'h0100, 1'b0, 1'b0);
    chk("t4_shift_ovf", bus.ovf, 1'b1);
    run_op(16'h00FF, 16'h0101, 1'b0, 1'b0);
    chk("t4_product", bus.product, 16'hFFFF);
    run_op(16'h0123, 16'h0045, 1'b1, 1'b0);
    run_op(16'h8001, 16'h0003, 1'b0, 1'b1);

    for (int r = 0; r < 16; r++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (r % 4 == 1) rb = rb & 16'h00FF;
      if (r % 4 == 2) ra = ra & 16'h00FF;
      run_op(ra, rb, 1'b0, 1'b0);
    end

    // Flush at cycle 5: no done, previous result retained, ALU back to idle.
    begin
      int dones;
      bus.a_in  = 16'h7777;
      bus.b_in  = 16'hF0F0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_busy", bus.busy, 1'b0);
      chk("flush_product", bus.product, exp_prod);
      chk("flush_ovf", bus.ovf, exp_ovf);
      chk("flush_alu_op", bus.alu_op, `OP_ID);
      dones = 0;
      for (int i = 0; i < 60; i++) begin
        if (bus.done || bus.busy) dones++;
        @(posedge clk); #1;
      end
      chk("flush_no_done", dones, 0);
    end

    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.a_in  = 16'h0002;
    bus.b_in  = 16'h0002;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_beats_start", bus.busy, 1'b0);

    run_op(16'h0011, 16'h0101, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an operation.
    bus.a_in  = 16'hABCD;
    bus.b_in  = 16'h1357;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_product", bus.product, 16'd0);
    chk("arst_ovf", bus.ovf, 1'b0);
    chk("arst_alu_op", bus.alu_op, `OP_ID);
    chk("arst_alu_a", bus.alu_a, 16'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0007, 16'h0009, 1'b0, 1'b0);

    chk("alu_cin_zero", cin_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
